// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO drain that packs `pack` consecutive words into one wide valid/ready beat.
// Optional partial-word flush is enabled with the FIFO_PACKER_FLUSH_EN macro.
module fifo_rd_packer #(
  parameter int data_width = 8,
  parameter int pack       = 4,
  parameter int cnt_width  = $clog2(pack) + 1
) (
  input  logic                         rclk,
  input  logic                         rrst,
  input  logic                         empty,
  output logic                         r_en,
  input  logic [data_width-1:0]        fifo_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [data_width*pack-1:0]   m_data
`ifdef FIFO_PACKER_FLUSH_EN
  ,
  input  logic                         flush,
  output logic [cnt_width-1:0]         m_count
`endif
);

  localparam logic [cnt_width-1:0] pack_cnt = cnt_width'(pack);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t                  state;
  out_state_t                  state_next;
  logic                        pend;
  logic [cnt_width-1:0]        lane_cnt;
  logic [data_width*pack-1:0]  asm_data;
  logic [cnt_width:0]          in_use;
  logic                        full_word;
  logic                        read_ok;
  logic                        eligible;
  logic                        transfer;
`ifdef FIFO_PACKER_FLUSH_EN
  logic                        flush_req;
`endif

  // in_use counts captured lanes plus the read still in flight
  always_comb begin
    in_use    = {1'b0, lane_cnt} + {{cnt_width{1'b0}}, pend};
    full_word = (lane_cnt == pack_cnt);
`ifdef FIFO_PACKER_FLUSH_EN
    read_ok   = (in_use < {1'b0, pack_cnt}) && !flush_req;
    eligible  = full_word || (flush_req && !pend && (lane_cnt != {cnt_width{1'b0}}));
`else
    read_ok   = (in_use < {1'b0, pack_cnt});
    eligible  = full_word;
`endif
    transfer  = eligible && ((state == OUT_EMPTY) || m_ready);
    r_en      = !rrst && !empty && read_ok;
  end

  always_comb begin
    state_next = state;
    case (state)
      OUT_EMPTY: begin
        if (transfer) begin
          state_next = OUT_FULL;
        end else begin
          state_next = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (transfer) begin
          state_next = OUT_FULL;
        end else if (m_ready) begin
          state_next = OUT_EMPTY;
        end else begin
          state_next = OUT_FULL;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  assign m_valid = (state == OUT_FULL);

  // A transfer never coincides with a capture: eligibility requires no read in flight
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pend     <= 1'b0;
      lane_cnt <= {cnt_width{1'b0}};
      asm_data <= {(data_width*pack){1'b0}};
      m_data   <= {(data_width*pack){1'b0}};
    end else begin
      pend <= r_en;
      if (transfer) begin
        m_data   <= asm_data;
        asm_data <= {(data_width*pack){1'b0}};
        lane_cnt <= {cnt_width{1'b0}};
      end else if (pend) begin
        for (int i = 0; i < pack; i++) begin
          if (lane_cnt == cnt_width'(i)) begin
            asm_data[i*data_width +: data_width] <= fifo_data;
          end
        end
        lane_cnt <= lane_cnt + cnt_width'(1);
      end
    end
  end

`ifdef FIFO_PACKER_FLUSH_EN
  // A flush with a read in flight is remembered until that word lands
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      flush_req <= 1'b0;
      m_count   <= {cnt_width{1'b0}};
    end else begin
      if (transfer) begin
        flush_req <= 1'b0;
        m_count   <= lane_cnt;
      end else if (flush && ((lane_cnt != {cnt_width{1'b0}}) || pend)) begin
        flush_req <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO read-port model, output monitor, linear test steps.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        empty = 1'b1;
  logic        r_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
`ifdef FIFO_PACKER_FLUSH_EN
  logic        flush = 1'b0;
  logic [2:0]  m_count;
`endif

  fifo_rd_packer #(.data_width(8), .pack(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .empty     (empty),
    .r_en      (r_en),
    .fifo_data (fifo_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_PACKER_FLUSH_EN
    ,
    .flush     (flush),
    .m_count   (m_count)
`endif
  );

  always #5 rclk = ~rclk;

  logic [7:0]  fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          reads = 0;
  int          viol = 0;
  int          cyc = 0;
  int          rd_cyc [0:255];
  bit          toggle = 1'b0;
  logic [31:0] out_log [0:63];
  logic [2:0]  cnt_log [0:63];
  int          out_n = 0;
  int          vcyc = 0;
  int          total = 0;
  int          bad = 0;

  // FIFO read port: registered data one cycle after r_en, registered empty flag
  always @(posedge rclk) begin : fifo_model
    int avail;
    avail = wr_ptr - rd_ptr;
    cyc <= cyc + 1;
    if (r_en) begin
      if (empty) viol <= viol + 1;
      rd_cyc[reads[7:0]] <= cyc;
      reads <= reads + 1;
      fifo_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
      avail = avail - 1;
    end
    empty <= (avail <= 0) || (toggle && !empty);
  end

  always @(negedge rclk) begin
    if (m_valid) vcyc <= vcyc + 1;
    if (m_valid && m_ready) begin
      out_log[out_n[5:0]] <= m_data;
`ifdef FIFO_PACKER_FLUSH_EN
      cnt_log[out_n[5:0]] <= m_count;
`else
      cnt_log[out_n[5:0]] <= 3'd0;
`endif
      out_n <= out_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  initial begin
    int b_r;
    int b_o;
    int b_v;
    int i;

    tick(2);
    chk("reset_r_en", {63'd0, r_en}, 64'd0);
    chk("reset_m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset_m_data", {32'd0, m_data}, 64'd0);
    rrst = 1'b0;
    tick(2);

    // four words, output always ready
    b_r = reads; b_o = out_n; b_v = vcyc;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    m_ready = 1'b1;
    tick(20);
    chk("t1_reads", 64'(reads - b_r), 64'd4);
    chk("t1_consecutive", 64'(rd_cyc[(b_r + 3) & 255] - rd_cyc[b_r & 255]), 64'd3);
    chk("t1_beats", 64'(out_n - b_o), 64'd1);
    chk("t1_data", {32'd0, out_log[b_o & 63]}, 64'h44332211);
    chk("t1_valid_cycles", 64'(vcyc - b_v), 64'd1);

    // twelve words with the output stalled, then released
    m_ready = 1'b0;
    b_r = reads; b_o = out_n;
    for (i = 1; i <= 12; i++) push(8'(i * 17));
    tick(30);
    chk("t2_stall_reads", 64'(reads - b_r), 64'd8);
    chk("t2_stall_valid", {63'd0, m_valid}, 64'd1);
    chk("t2_stall_data", {32'd0, m_data}, 64'h44332211);
    chk("t2_stall_beats", 64'(out_n - b_o), 64'd0);
    m_ready = 1'b1;
    tick(30);
    chk("t2_beats", 64'(out_n - b_o), 64'd3);
    chk("t2_word0", {32'd0, out_log[b_o & 63]}, 64'h44332211);
    chk("t2_word1", {32'd0, out_log[(b_o + 1) & 63]}, 64'h88776655);
    chk("t2_word2", {32'd0, out_log[(b_o + 2) & 63]}, 64'hCCBBAA99);
    chk("t2_reads", 64'(reads - b_r), 64'd12);

    // empty toggling every cycle
    toggle = 1'b1;
    b_r = reads; b_o = out_n;
    for (i = 1; i <= 8; i++) push(8'(i));
    tick(40);
    chk("t3_no_read_on_empty", 64'(viol), 64'd0);
    chk("t3_reads", 64'(reads - b_r), 64'd8);
    chk("t3_beats", 64'(out_n - b_o), 64'd2);
    chk("t3_word0", {32'd0, out_log[b_o & 63]}, 64'h04030201);
    chk("t3_word1", {32'd0, out_log[(b_o + 1) & 63]}, 64'h08070605);
    toggle = 1'b0;
    tick(2);

    // reset with two lanes captured and a third read in flight
    b_r = reads; b_o = out_n;
    push(8'hB1); push(8'hB2); push(8'hB3);
    push(8'hC4); push(8'hC5); push(8'hC6); push(8'hC7);
    for (i = 0; i < 20 && (reads - b_r) < 3; i++) tick(1);
    chk("t4_reads_before_reset", 64'(reads - b_r), 64'd3);
    rrst = 1'b1;
    #1;
    chk("t4_r_en_in_reset", {63'd0, r_en}, 64'd0);
    tick(2);
    chk("t4_r_en_held_reset", {63'd0, r_en}, 64'd0);
    rrst = 1'b0;
    tick(20);
    chk("t4_beats", 64'(out_n - b_o), 64'd1);
    chk("t4_clean_word", {32'd0, out_log[b_o & 63]}, 64'hC7C6C5C4);
    chk("t4_reads", 64'(reads - b_r), 64'd7);

    // asynchronous reset while a word is held on the output
    m_ready = 1'b0;
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    for (i = 0; i < 30 && !m_valid; i++) tick(1);
    chk("t5_valid_before", {63'd0, m_valid}, 64'd1);
    chk("t5_data_before", {32'd0, m_data}, 64'hD3D2D1D0);
    #2;
    rrst = 1'b1;
    #1;
    chk("t5_async_r_en", {63'd0, r_en}, 64'd0);
    chk("t5_async_valid", {63'd0, m_valid}, 64'd0);
    chk("t5_async_data", {32'd0, m_data}, 64'd0);
    tick(1);
    rrst = 1'b0;
    tick(2);

`ifdef FIFO_PACKER_FLUSH_EN
    // partial word flushed, then a full word
    m_ready = 1'b1;
    b_o = out_n;
    push(8'h11); push(8'h22);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    chk("t6_flush_beats", 64'(out_n - b_o), 64'd1);
    chk("t6_flush_data", {32'd0, out_log[b_o & 63]}, 64'h00002211);
    chk("t6_flush_count", {61'd0, cnt_log[b_o & 63]}, 64'd2);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    tick(20);
    chk("t6_full_beats", 64'(out_n - b_o), 64'd2);
    chk("t6_full_data", {32'd0, out_log[(b_o + 1) & 63]}, 64'h88776655);
    chk("t6_full_count", {61'd0, cnt_log[(b_o + 1) & 63]}, 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
